// File: rtl/neural_network_pkg.sv
// Shared types, limits and helpers for the neural-network layer sequencing blocks.
package neural_network_pkg;

   localparam int unsigned MAX_MAC_LATENCY = 7;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      MAC   = 3'd1,
      BIAS  = 3'd2,
      DRAIN = 3'd3,
      WRITE = 3'd4,
      DONE  = 3'd5
   } scheduler_state;

   typedef enum logic [1:0] {
      ACT_NONE    = 2'd0,
      ACT_RELU    = 2'd1,
      ACT_SIGMOID = 2'd2,
      ACT_TANH    = 2'd3
   } activation_type;

   // Index width that stays at least one bit for single-entry ranges.
   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/dense_layer_scheduler_wrap_counter.sv
// Modulo-MODULUS up-counter with synchronous clear; terminal_c_o marks the increment that wraps to 0.
module wrap_counter
   import neural_network_pkg::*;
#(
   parameter int unsigned MODULUS = 4,
   parameter int unsigned WIDTH   = idx_width(MODULUS)
) (
   input  logic             clock_i,
   input  logic             reset_ni,
   input  logic             clear_i,
   input  logic             incr_i,
   output logic [WIDTH-1:0] count_o,
   output logic [WIDTH-1:0] count_next_c_o,
   output logic             terminal_c_o
);

   localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);

   logic [WIDTH-1:0] count_q, count_d;
   logic             at_last;

   assign at_last = (count_q == LAST);

   always_comb begin
      count_d = count_q;
      if (clear_i) begin
         count_d = '0;
      end else if (incr_i) begin
         count_d = at_last ? '0 : count_q + WIDTH'(1);
      end
   end

   always_ff @(posedge clock_i or negedge reset_ni) begin
      if (!reset_ni) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o        = count_q;
   assign count_next_c_o = count_d;
   assign terminal_c_o   = incr_i & ~clear_i & at_last;

endmodule

// File: rtl/dense_layer_scheduler.sv
// Serial sequencer driving one shared MAC/activation datapath through every neuron of a dense layer.
// Define DENSE_LAYER_SCHEDULER_QUEUE_EN to remember one start request that arrives while busy.
module dense_layer_scheduler
   import neural_network_pkg::*;
#(
   parameter int unsigned NUM_INPUTS  = 4,
   parameter int unsigned NUM_NEURONS = 4,
   parameter int unsigned MAC_LATENCY = 1,
   parameter int unsigned ADDR_WIDTH  = $clog2(NUM_NEURONS * (NUM_INPUTS + 1)),
   localparam int unsigned IDX_W      = idx_width(NUM_INPUTS),
   localparam int unsigned NEU_W      = idx_width(NUM_NEURONS)
) (
   input  logic                  clock_i,
   input  logic                  reset_ni,
   input  logic                  inputs_ready_i,
   output logic                  busy_o,
   output logic [IDX_W-1:0]      input_index_o,
   output logic [ADDR_WIDTH-1:0] weight_address_o,
   output logic                  mac_clear_o,
   output logic                  mac_enable_o,
   output logic                  bias_enable_o,
   output logic                  output_write_o,
   output logic [NEU_W-1:0]      output_index_o,
   output logic                  outputs_ready_o
);

   localparam int unsigned DRAIN_MOD = (MAC_LATENCY > 0) ? MAC_LATENCY : 1;
   localparam int unsigned DRAIN_W   = idx_width(DRAIN_MOD);

   scheduler_state state_q, state_d;

   logic               k_clr, k_inc, k_term;
   logic               n_clr, n_inc, n_term;
   logic               d_clr, d_inc, d_term;
   logic [IDX_W-1:0]   k_count, k_next;
   logic [NEU_W-1:0]   n_count, n_next;
   logic [DRAIN_W-1:0] d_count, d_next;
   logic               restart_c;

   // Counter controls depend only on the current state, so the terminal pulses feed the FSM loop-free.
   assign k_clr = (state_q == IDLE);
   assign k_inc = (state_q == MAC);
   assign n_clr = (state_q == IDLE);
   assign n_inc = (state_q == WRITE);
   assign d_clr = (state_q == BIAS);
   assign d_inc = (state_q == DRAIN);

   wrap_counter #(.MODULUS(NUM_INPUTS), .WIDTH(IDX_W)) u_input_cnt (
      .clock_i        (clock_i),
      .reset_ni       (reset_ni),
      .clear_i        (k_clr),
      .incr_i         (k_inc),
      .count_o        (k_count),
      .count_next_c_o (k_next),
      .terminal_c_o   (k_term)
   );

   wrap_counter #(.MODULUS(NUM_NEURONS), .WIDTH(NEU_W)) u_neuron_cnt (
      .clock_i        (clock_i),
      .reset_ni       (reset_ni),
      .clear_i        (n_clr),
      .incr_i         (n_inc),
      .count_o        (n_count),
      .count_next_c_o (n_next),
      .terminal_c_o   (n_term)
   );

   wrap_counter #(.MODULUS(DRAIN_MOD), .WIDTH(DRAIN_W)) u_drain_cnt (
      .clock_i        (clock_i),
      .reset_ni       (reset_ni),
      .clear_i        (d_clr),
      .incr_i         (d_inc),
      .count_o        (d_count),
      .count_next_c_o (d_next),
      .terminal_c_o   (d_term)
   );

   logic counts_unused;
   assign counts_unused = ^{k_count, n_count, d_count, d_next};

`ifdef DENSE_LAYER_SCHEDULER_QUEUE_EN
   logic pend_q, pend_d;

   // One-deep pending start: set while busy, consumed by the DONE cycle.
   always_comb begin
      pend_d = pend_q;
      if (state_q == DONE) begin
         pend_d = 1'b0;
      end else if ((state_q != IDLE) && inputs_ready_i) begin
         pend_d = 1'b1;
      end
   end

   always_ff @(posedge clock_i or negedge reset_ni) begin
      if (!reset_ni) begin
         pend_q <= 1'b0;
      end else begin
         pend_q <= pend_d;
      end
   end

   assign restart_c = pend_q | inputs_ready_i;
`else
   assign restart_c = 1'b0;
`endif

   always_ff @(posedge clock_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:  if (inputs_ready_i) state_d = MAC;
         MAC:   if (k_term) state_d = BIAS;
         BIAS:  state_d = (MAC_LATENCY != 0) ? DRAIN : WRITE;
         DRAIN: if (d_term) state_d = WRITE;
         WRITE: state_d = n_term ? DONE : MAC;
         DONE:  state_d = restart_c ? MAC : IDLE;
         default: state_d = IDLE;
      endcase
   end

   logic                  busy_q, busy_d;
   logic [IDX_W-1:0]      input_index_q, input_index_d;
   logic [ADDR_WIDTH-1:0] weight_address_q, weight_address_d;
   logic                  mac_clear_q, mac_clear_d;
   logic                  mac_enable_q, mac_enable_d;
   logic                  bias_enable_q, bias_enable_d;
   logic                  output_write_q, output_write_d;
   logic [NEU_W-1:0]      output_index_q, output_index_d;
   logic                  outputs_ready_q, outputs_ready_d;
   logic [ADDR_WIDTH-1:0] neuron_base;

   assign neuron_base = ADDR_WIDTH'(n_next) * ADDR_WIDTH'(NUM_INPUTS + 1);

   // Outputs are decoded from the upcoming state and counts, then registered.
   always_comb begin
      busy_d           = (state_d != IDLE);
      input_index_d    = input_index_q;
      weight_address_d = weight_address_q;
      output_index_d   = output_index_q;
      mac_clear_d      = 1'b0;
      mac_enable_d     = 1'b0;
      bias_enable_d    = 1'b0;
      output_write_d   = 1'b0;
      outputs_ready_d  = 1'b0;
      unique case (state_d)
         MAC: begin
            mac_enable_d     = 1'b1;
            mac_clear_d      = (k_next == '0);
            input_index_d    = k_next;
            weight_address_d = neuron_base + ADDR_WIDTH'(k_next);
         end
         BIAS: begin
            bias_enable_d    = 1'b1;
            weight_address_d = neuron_base + ADDR_WIDTH'(NUM_INPUTS);
         end
         WRITE: begin
            output_write_d = 1'b1;
            output_index_d = n_next;
         end
         DONE: outputs_ready_d = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clock_i or negedge reset_ni) begin
      if (!reset_ni) begin
         busy_q           <= 1'b0;
         input_index_q    <= '0;
         weight_address_q <= '0;
         mac_clear_q      <= 1'b0;
         mac_enable_q     <= 1'b0;
         bias_enable_q    <= 1'b0;
         output_write_q   <= 1'b0;
         output_index_q   <= '0;
         outputs_ready_q  <= 1'b0;
      end else begin
         busy_q           <= busy_d;
         input_index_q    <= input_index_d;
         weight_address_q <= weight_address_d;
         mac_clear_q      <= mac_clear_d;
         mac_enable_q     <= mac_enable_d;
         bias_enable_q    <= bias_enable_d;
         output_write_q   <= output_write_d;
         output_index_q   <= output_index_d;
         outputs_ready_q  <= outputs_ready_d;
      end
   end

   assign busy_o           = busy_q;
   assign input_index_o    = input_index_q;
   assign weight_address_o = weight_address_q;
   assign mac_clear_o      = mac_clear_q;
   assign mac_enable_o     = mac_enable_q;
   assign bias_enable_o    = bias_enable_q;
   assign output_write_o   = output_write_q;
   assign output_index_o   = output_index_q;
   assign outputs_ready_o  = outputs_ready_q;

endmodule

// File: tb/tb_dense_layer_scheduler.sv
// Bench for dense_layer_scheduler: directed vector table, event scoreboard and reset/queue sequences.
module tb_dense_layer_scheduler;

   localparam int unsigned NI  = 4;
   localparam int unsigned NN  = 4;
   localparam int unsigned ML  = 1;
   localparam int unsigned PER = NI + ML + 2;
   localparam int unsigned AW  = $clog2(NN * (NI + 1));
`ifdef DENSE_LAYER_SCHEDULER_QUEUE_EN
   localparam int QUEUED = 1;
`else
   localparam int QUEUED = 0;
`endif

   logic          clk = 1'b0;
   logic          rst_n;
   logic          in_rdy;
   logic          busy, clr, mac, bias, wr, rdy;
   logic [1:0]    in_idx, oidx;
   logic [AW-1:0] waddr;

   logic          in_s;
   logic          busy_s, clr_s, mac_s, bias_s, wr_s, rdy_s;
   logic [0:0]    idx_s, addr_s, oidx_s;

   dense_layer_scheduler #(.NUM_INPUTS(NI), .NUM_NEURONS(NN), .MAC_LATENCY(ML)) dut (
      .clock_i          (clk),
      .reset_ni         (rst_n),
      .inputs_ready_i   (in_rdy),
      .busy_o           (busy),
      .input_index_o    (in_idx),
      .weight_address_o (waddr),
      .mac_clear_o      (clr),
      .mac_enable_o     (mac),
      .bias_enable_o    (bias),
      .output_write_o   (wr),
      .output_index_o   (oidx),
      .outputs_ready_o  (rdy)
   );

   dense_layer_scheduler #(.NUM_INPUTS(1), .NUM_NEURONS(1), .MAC_LATENCY(0)) dut_small (
      .clock_i          (clk),
      .reset_ni         (rst_n),
      .inputs_ready_i   (in_s),
      .busy_o           (busy_s),
      .input_index_o    (idx_s),
      .weight_address_o (addr_s),
      .mac_clear_o      (clr_s),
      .mac_enable_o     (mac_s),
      .bias_enable_o    (bias_s),
      .output_write_o   (wr_s),
      .output_index_o   (oidx_s),
      .outputs_ready_o  (rdy_s)
   );

   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_errors = 0;
   int n_writes = 0;
   bit mon_en   = 1'b0;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // kind: 0 mac, 1 bias, 2 write, 3 outputs_ready
   typedef struct {
      int unsigned cyc;
      int          kind;
      int          idx;
      int          addr;
      logic        clr;
   } ev_t;
   ev_t sbq[$];

   task automatic push_run(input int unsigned c0);
      ev_t e;
      for (int unsigned n = 0; n < NN; n++) begin
         for (int unsigned k = 0; k < NI; k++) begin
            e.cyc = c0 + 1 + n * PER + k; e.kind = 0; e.idx = int'(k);
            e.addr = int'(n * (NI + 1) + k); e.clr = (k == 0);
            sbq.push_back(e);
         end
         e.cyc = c0 + 1 + n * PER + NI; e.kind = 1; e.idx = 0;
         e.addr = int'(n * (NI + 1) + NI); e.clr = 1'b0;
         sbq.push_back(e);
         e.cyc = c0 + 1 + n * PER + NI + 1 + ML; e.kind = 2; e.idx = int'(n); e.addr = 0;
         sbq.push_back(e);
      end
      e.cyc = c0 + 1 + NN * PER; e.kind = 3; e.idx = 0; e.addr = 0; e.clr = 1'b0;
      sbq.push_back(e);
   endtask

   always @(negedge clk) begin : monitor
      ev_t e;
      int  k_act;
      if (mon_en) begin
         chk("strobe_exclusive", int'(int'(mac) + int'(bias) + int'(wr) > 1), 0);
         chk("addr_range", int'(int'(waddr) < int'(NN * (NI + 1))), 1);
         chk("clear_without_mac", int'(clr & ~mac), 0);
         while (sbq.size() > 0 && sbq[0].cyc < cyc) begin
            chk("event_on_time", int'(cyc), int'(sbq[0].cyc));
            void'(sbq.pop_front());
         end
         if (mac | bias | wr | rdy) begin
            if (wr) n_writes++;
            k_act = mac ? 0 : bias ? 1 : wr ? 2 : 3;
            if (sbq.size() == 0 || sbq[0].cyc != cyc) begin
               chk("unexpected_strobe_kind", k_act, -1);
            end else begin
               e = sbq.pop_front();
               chk("event_kind", k_act, e.kind);
               case (e.kind)
                  0: begin
                     chk("mac_input_index", int'(in_idx), e.idx);
                     chk("mac_weight_address", int'(waddr), e.addr);
                     chk("mac_clear", int'(clr), int'(e.clr));
                  end
                  1: chk("bias_weight_address", int'(waddr), e.addr);
                  2: chk("write_output_index", int'(oidx), e.idx);
                  default: ;
               endcase
            end
         end
      end
   end

   task automatic to_cycle(input int unsigned t);
      while (cyc < t) @(negedge clk);
   endtask

   typedef struct {
      int unsigned rc;
      logic        rdy_in;
      logic        start;
      logic [5:0]  flags;   // {busy, mac_clear, mac_enable, bias_enable, output_write, outputs_ready}
      int          idx;
      int          addr;
      int          oidx;
   } vec_t;
   vec_t tbl[$];

   task automatic row(input int unsigned rc, input logic ri, input logic st, input logic [5:0] fl,
                      input int idx, input int addr, input int oi);
      vec_t v;
      v.rc = rc; v.rdy_in = ri; v.start = st; v.flags = fl; v.idx = idx; v.addr = addr; v.oidx = oi;
      tbl.push_back(v);
   endtask

   logic [5:0]  small_exp [5];
   int unsigned base, c0, c1;

   initial begin
      row( 0, 1'b1, 1'b1, 6'b000000, -1, -1, -1);
      row( 1, 1'b0, 1'b0, 6'b111000,  0,  0, -1);
      row( 2, 1'b0, 1'b0, 6'b101000,  1,  1, -1);
      row( 3, 1'b0, 1'b0, 6'b101000,  2,  2, -1);
      row( 4, 1'b0, 1'b0, 6'b101000,  3,  3, -1);
      row( 5, 1'b0, 1'b0, 6'b100100, -1,  4, -1);
      row( 6, 1'b0, 1'b0, 6'b100000, -1, -1, -1);
      row( 7, 1'b0, 1'b0, 6'b100010, -1, -1,  0);
      row( 8, 1'b0, 1'b0, 6'b111000,  0,  5, -1);
      row(28, 1'b0, 1'b0, 6'b100010, -1, -1,  3);
      row(29, 1'b0, 1'b0, 6'b100001, -1, -1, -1);
      row(30, 1'b0, 1'b0, 6'b000000, -1, -1, -1);
      small_exp = '{6'b111000, 6'b100100, 6'b100010, 6'b100001, 6'b000000};

      rst_n = 1'b0; in_rdy = 1'b0; in_s = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_outputs", int'({busy, clr, mac, bias, wr, rdy, in_idx, waddr, oidx}), 0);
      chk("reset_outputs_small", int'({busy_s, clr_s, mac_s, bias_s, wr_s, rdy_s, idx_s, addr_s, oidx_s}), 0);
      rst_n = 1'b1; mon_en = 1'b1;
      @(negedge clk);

      // Single start through the whole default layer
      base = cyc + 1; n_writes = 0;
      foreach (tbl[i]) begin
         to_cycle(base + tbl[i].rc);
         chk("tbl_flags", int'(tbl[i].flags), int'({busy, clr, mac, bias, wr, rdy}));
         if (tbl[i].idx >= 0)  chk("tbl_input_index", int'(in_idx), tbl[i].idx);
         if (tbl[i].addr >= 0) chk("tbl_weight_address", int'(waddr), tbl[i].addr);
         if (tbl[i].oidx >= 0) chk("tbl_output_index", int'(oidx), tbl[i].oidx);
         in_rdy = tbl[i].rdy_in;
         if (tbl[i].start) push_run(cyc);
      end
      to_cycle(cyc + 2);
      chk("writes_per_start", n_writes, int'(NN));
      chk("scoreboard_drained", sbq.size(), 0);

      // Minimal configuration: one input, one neuron, no drain
      @(negedge clk); in_s = 1'b1; c0 = cyc;
      @(negedge clk); in_s = 1'b0;
      for (int unsigned i = 0; i < 5; i++) begin
         to_cycle(c0 + 1 + i);
         chk("small_flags", int'({busy_s, clr_s, mac_s, bias_s, wr_s, rdy_s}), int'(small_exp[i]));
         if (i == 0) chk("small_mac_address", int'({idx_s, addr_s}), 0);
         if (i == 1) chk("small_bias_address", int'(addr_s), 1);
         if (i == 2) chk("small_output_index", int'(oidx_s), 0);
      end

      // Starts arriving while busy, including the DONE cycle
      @(negedge clk); n_writes = 0; c0 = cyc; in_rdy = 1'b1; push_run(c0);
      to_cycle(c0 + 1);  in_rdy = 1'b0;
      to_cycle(c0 + 10); in_rdy = 1'b1;
      to_cycle(c0 + 11); in_rdy = 1'b0;
      to_cycle(c0 + 29); in_rdy = 1'b1;
      if (QUEUED != 0) push_run(c0 + 29);
      to_cycle(c0 + 30); in_rdy = 1'b0;
      chk("busy_after_done", int'(busy), QUEUED);
      chk("clear_after_done", int'(clr), QUEUED);
      to_cycle(c0 + 62);
      chk("busy_settled", int'(busy), 0);
      chk("writes_busy_starts", n_writes, int'(NN) * (1 + QUEUED));
      chk("scoreboard_drained_busy", sbq.size(), 0);

      // Reset in mid-computation, then a clean restart
      @(negedge clk); n_writes = 0; c0 = cyc; in_rdy = 1'b1; push_run(c0);
      to_cycle(c0 + 1); in_rdy = 1'b0;
      to_cycle(c0 + 12);
      #2 rst_n = 1'b0; sbq.delete();
      #1 chk("async_reset_outputs", int'({busy, clr, mac, bias, wr, rdy, in_idx, waddr, oidx}), 0);
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1; n_writes = 0;
      @(negedge clk); c1 = cyc; in_rdy = 1'b1; push_run(c1);
      to_cycle(c1 + 1); in_rdy = 1'b0;
      to_cycle(c1 + 31);
      chk("busy_after_restart", int'(busy), 0);
      chk("writes_after_restart", n_writes, int'(NN));
      chk("scoreboard_drained_restart", sbq.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
